// File: rtl/rr_pkg.sv
// -----------------------------------------------------------------------------
// rr_pkg
// Shared types for the RR_Module note sequencer.
//   rr_state_e : sequencer FSM states (GAP is only reachable when the
//                RR_SEQ_GAP_EN build macro is defined)
//   rr_note_t  : one song ROM entry {dur, pitch} at the default widths
//   END_MARKER : duration code that terminates a song
// -----------------------------------------------------------------------------
package rr_pkg;

    localparam int RR_PITCH_W = 8;
    localparam int RR_DUR_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4
    } rr_state_e;

    typedef struct packed {
        logic [RR_DUR_W-1:0]   dur;
        logic [RR_PITCH_W-1:0] pitch;
    } rr_note_t;

    localparam logic [RR_DUR_W-1:0] END_MARKER = 4'd0;

endpackage

// File: rtl/rr_note_sequencer_if.sv
// -----------------------------------------------------------------------------
// rr_note_sequencer_if
// Bundles the sequencer's control handshake, song ROM bus and tone generator
// outputs.
//   master : the sequencer (drives rom_addr, tone_*, note_strobe, busy, done)
//   slave  : the surrounding module / ROM (drives start, stop, loop, rom_data)
// -----------------------------------------------------------------------------
interface rr_note_sequencer_if #(
    parameter int ADDR_W  = 6,
    parameter int PITCH_W = 8,
    parameter int DUR_W   = 4
);
    logic                       start;
    logic                       stop;
    logic                       loop;
    logic [ADDR_W-1:0]          rom_addr;
    logic [DUR_W+PITCH_W-1:0]   rom_data;
    logic [PITCH_W-1:0]         tone_pitch;
    logic                       tone_en;
    logic                       note_strobe;
    logic                       busy;
    logic                       done;

    modport master (
        input  start, stop, loop, rom_data,
        output rom_addr, tone_pitch, tone_en, note_strobe, busy, done
    );

    modport slave (
        output start, stop, loop, rom_data,
        input  rom_addr, tone_pitch, tone_en, note_strobe, busy, done
    );
endinterface

// File: rtl/rr_beat_timer.sv
// -----------------------------------------------------------------------------
// rr_beat_timer
// BEAT_CYCLES prescaler. load_i restarts a beat; while en_i is high the
// counter runs down and beat_tick_o pulses for one cycle on the last cycle
// of every beat, after which the counter reloads itself.
//   clock, reset  : system clock, synchronous active-high reset
//   load_i        : start a fresh beat (wins over en_i)
//   en_i          : count this cycle
//   beat_tick_o   : last cycle of the current beat
// -----------------------------------------------------------------------------
module rr_beat_timer #(
    parameter int BEAT_CYCLES = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic beat_tick_o
);
    localparam int              CNT_W  = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load, run down with self-reload, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (en_i) begin
            if (cnt_q == ZERO) begin
                cnt_d = RELOAD;
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign beat_tick_o = en_i & ~load_i & (cnt_q == ZERO);

endmodule

// File: rtl/rr_note_sequencer.sv
// -----------------------------------------------------------------------------
// rr_note_sequencer
// Walks a song ROM of {dur, pitch} entries and drives the tone generator.
// Each note sounds for dur*BEAT_CYCLES cycles; dur==0 or finishing the last
// ROM address ends the song (restart at 0 when loop is high, else pulse done).
// Build macro RR_SEQ_GAP_EN: adds GAP_CYCLES of silence after each note.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus (master) : start/stop/loop in, rom_addr out / rom_data in,
//                  tone_pitch/tone_en/note_strobe out, busy/done out
// All bus outputs are registered.
// -----------------------------------------------------------------------------
module rr_note_sequencer
    import rr_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int PITCH_W     = 8,
    parameter int DUR_W       = 4,
    parameter int BEAT_CYCLES = 1000,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    rr_note_sequencer_if.master    bus
);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
    localparam logic [DUR_W-1:0]  DUR_END   = DUR_W'(END_MARKER);

    rr_state_e            state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [PITCH_W-1:0]   pitch_q, pitch_d;
    logic                 tone_en_q, tone_en_d;
    logic                 strobe_q, strobe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DUR_W-1:0]     dur_q, dur_d;

    logic                 timer_load_s;
    logic                 timer_en_s;
    logic                 beat_tick_s;
    logic                 abort_s;
    logic                 end_song_s;
    logic                 advance_s;

    logic [DUR_W-1:0]     entry_dur_s;
    logic [PITCH_W-1:0]   entry_pitch_s;

    assign entry_dur_s   = bus.rom_data[DUR_W+PITCH_W-1:PITCH_W];
    assign entry_pitch_s = bus.rom_data[PITCH_W-1:0];

`ifdef RR_SEQ_GAP_EN
    localparam int              GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ZERO   = GAP_W'(0);
    localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    rr_beat_timer #(
        .BEAT_CYCLES (BEAT_CYCLES)
    ) u_beat_timer (
        .clock       (clock),
        .reset       (reset),
        .load_i      (timer_load_s),
        .en_i        (timer_en_s),
        .beat_tick_o (beat_tick_s)
    );

    // Next-state and output decode. Each state raises abort/end_song/advance
    // flags; the common actions for those are resolved after the case so stop
    // always overrides everything else.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pitch_d      = pitch_q;
        tone_en_d    = tone_en_q;
        strobe_d     = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        dur_d        = dur_q;
        timer_load_s = 1'b0;
        timer_en_s   = 1'b0;
        abort_s      = 1'b0;
        end_song_s   = 1'b0;
        advance_s    = 1'b0;
`ifdef RR_SEQ_GAP_EN
        gap_d        = gap_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // stop beats a simultaneous start.
                if (bus.start && !bus.stop) begin
                    state_d = ST_FETCH;
                    addr_d  = ADDR_ZERO;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.stop) begin
                    abort_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.stop) begin
                    abort_s = 1'b1;
                end else if (entry_dur_s == DUR_END) begin
                    end_song_s = 1'b1;
                end else begin
                    pitch_d      = entry_pitch_s;
                    dur_d        = entry_dur_s;
                    tone_en_d    = 1'b1;
                    strobe_d     = 1'b1;
                    timer_load_s = 1'b1;
                    state_d      = ST_PLAY;
                end
            end
            ST_PLAY: begin
                timer_en_s = 1'b1;
                if (bus.stop) begin
                    abort_s = 1'b1;
                end else if (beat_tick_s) begin
                    // The note ends on the tick that completes its last beat.
                    if (dur_q == DUR_ONE) begin
                        tone_en_d = 1'b0;
                        dur_d     = DUR_W'(0);
`ifdef RR_SEQ_GAP_EN
                        gap_d     = GAP_RELOAD;
                        state_d   = ST_GAP;
`else
                        advance_s = 1'b1;
`endif
                    end else begin
                        dur_d = dur_q - DUR_ONE;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
`ifdef RR_SEQ_GAP_EN
            ST_GAP: begin
                if (bus.stop) begin
                    abort_s = 1'b1;
                end else if (gap_q == GAP_ZERO) begin
                    advance_s = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
`endif
            default: begin
                abort_s = 1'b1;
            end
        endcase

        // Moving past the last address is an end of song, never a wrap.
        if (advance_s) begin
            if (addr_q == ADDR_LAST) begin
                end_song_s = 1'b1;
            end else begin
                addr_d  = addr_q + ADDR_ONE;
                state_d = ST_FETCH;
            end
        end else begin
            advance_s = 1'b0;
        end

        if (end_song_s) begin
            tone_en_d = 1'b0;
            addr_d    = ADDR_ZERO;
            if (bus.loop) begin
                state_d = ST_FETCH;
            end else begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        end else begin
            end_song_s = 1'b0;
        end

        if (abort_s) begin
            state_d   = ST_IDLE;
            tone_en_d = 1'b0;
            strobe_d  = 1'b0;
            addr_d    = ADDR_ZERO;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end else begin
            abort_s = 1'b0;
        end
    end

    // State and registered-output update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= ADDR_ZERO;
            pitch_q   <= PITCH_W'(0);
            tone_en_q <= 1'b0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dur_q     <= DUR_W'(0);
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pitch_q   <= pitch_d;
            tone_en_q <= tone_en_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dur_q     <= dur_d;
        end
    end

`ifdef RR_SEQ_GAP_EN
    // Silence counter between notes.
    always_ff @(posedge clock) begin
        if (reset) begin
            gap_q <= GAP_ZERO;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    assign bus.rom_addr    = addr_q;
    assign bus.tone_pitch  = pitch_q;
    assign bus.tone_en     = tone_en_q;
    assign bus.note_strobe = strobe_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_rr_note_sequencer.sv
// Directed bench for rr_note_sequencer with BEAT_CYCLES=4, ADDR_W=2.
module tb_rr_note_sequencer;
    import rr_pkg::*;

`ifdef RR_SEQ_GAP_EN
    localparam int EXP_LOW = 5;
`else
    localparam int EXP_LOW = 2;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   n;
    int   strobes;
    int   dones;
    int   guard;

    rr_note_t mem [4];

    rr_note_sequencer_if #(.ADDR_W(2), .PITCH_W(8), .DUR_W(4)) bus ();

    rr_note_sequencer #(
        .ADDR_W      (2),
        .PITCH_W     (8),
        .DUR_W       (4),
        .BEAT_CYCLES (4),
        .GAP_CYCLES  (3)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous song ROM: data valid the cycle after the address is sampled.
    always_ff @(posedge clk) begin
        bus.rom_data <= mem[bus.rom_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count consecutive cycles with tone_en at the given level (bounded).
    task automatic measure(input logic level, output int cnt);
        cnt = 0;
        while (bus.tone_en === level && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},   32'(bus.rom_addr),    32'd0);
        check({tag, "_pitch"},  32'(bus.tone_pitch),  32'd0);
        check({tag, "_en"},     32'(bus.tone_en),     32'd0);
        check({tag, "_strobe"}, 32'(bus.note_strobe), 32'd0);
        check({tag, "_busy"},   32'(bus.busy),        32'd0);
        check({tag, "_done"},   32'(bus.done),        32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        mem[0] = '{dur: 4'd3, pitch: 8'h21};
        mem[1] = '{dur: 4'd2, pitch: 8'h40};
        mem[2] = '{dur: 4'd0, pitch: 8'h00};
        mem[3] = '{dur: 4'd0, pitch: 8'h00};
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // 1: two-note song, no loop
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("s1_busy_on_accept", 32'(bus.busy), 32'd1);
        check("s1_en_n0", 32'(bus.tone_en), 32'd0);
        tick();
        check("s1_en_n1", 32'(bus.tone_en), 32'd0);
        tick();
        check("s1_strobe_n2", 32'(bus.note_strobe), 32'd1);
        check("s1_pitch0", 32'(bus.tone_pitch), 32'h21);
        measure(1'b1, n);
        check("s1_note0_len", 32'(n), 32'd12);
        measure(1'b0, n);
        check("s1_gap_len", 32'(n), 32'(EXP_LOW));
        check("s1_strobe1", 32'(bus.note_strobe), 32'd1);
        check("s1_pitch1", 32'(bus.tone_pitch), 32'h40);
        measure(1'b1, n);
        check("s1_note1_len", 32'(n), 32'd8);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            dones += int'(bus.done);
            tick();
        end
        check("s1_done_once", 32'(dones), 32'd1);
        check("s1_busy_off", 32'(bus.busy), 32'd0);
        check("s1_pitch_hold", 32'(bus.tone_pitch), 32'h40);

        // 2: same song looping
        bus.loop = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        strobes = 0;
        dones = 0;
        guard = 0;
        while (strobes < 4 && guard < 200) begin
            tick();
            guard++;
            dones += int'(bus.done);
            if (bus.note_strobe === 1'b1) begin
                strobes++;
                if (strobes == 3) begin
                    check("s2_replay_pitch", 32'(bus.tone_pitch), 32'h21);
                    check("s2_replay_addr", 32'(bus.rom_addr), 32'd0);
                end
            end
        end
        check("s2_strobes", 32'(strobes), 32'd4);
        check("s2_no_done", 32'(dones), 32'd0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        check("s2_stop_busy", 32'(bus.busy), 32'd0);
        check("s2_stop_en", 32'(bus.tone_en), 32'd0);

        // 3: stop mid-note, then replay
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("s3_playing", 32'(bus.tone_en), 32'd1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("s3_stop_en", 32'(bus.tone_en), 32'd0);
        check("s3_stop_busy", 32'(bus.busy), 32'd0);
        check("s3_stop_addr", 32'(bus.rom_addr), 32'd0);
        dones = int'(bus.done);
        repeat (4) begin
            tick();
            dones += int'(bus.done);
        end
        check("s3_no_done", 32'(dones), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("s3_restart_strobe", 32'(bus.note_strobe), 32'd1);
        measure(1'b1, n);
        check("s3_restart_len", 32'(n), 32'd12);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;

        // 4: start ignored while busy; reset mid-note
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("s4_strobe_once", 32'(bus.note_strobe), 32'd0);
        check("s4_busy", 32'(bus.busy), 32'd1);
        measure(1'b1, n);
        check("s4_note0_rest", 32'(n), 32'd11);
        measure(1'b0, n);
        check("s4_gap_len", 32'(n), 32'(EXP_LOW));
        check("s4_pitch1", 32'(bus.tone_pitch), 32'h40);
        tick();
        tick();
        check("s4_mid_note", 32'(bus.tone_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("s4_reset");
        tick();
        check("s4_idle_after_reset", 32'(bus.busy), 32'd0);

        // 5: full ROM, no end marker
        for (int i = 0; i < 4; i++) begin
            mem[i] = '{dur: 4'd1, pitch: 8'(8'h11 + i)};
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        strobes = 0;
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            dones += int'(bus.done);
            if (bus.note_strobe === 1'b1) begin
                check("s5_pitch", 32'(bus.tone_pitch), 32'(8'h11 + strobes));
                strobes++;
            end
        end
        check("s5_strobes", 32'(strobes), 32'd4);
        check("s5_done", 32'(dones), 32'd1);
        check("s5_busy_off", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rr_note_sequencer.md
Name: rr_note_sequencer

Overview:
Controller that sequences the tone datapath of RR_Module. It walks a song ROM of {duration, pitch} entries and times each note in beats from a clock-cycle prescaler. It drives the tone generator's pitch/enable inputs and exposes a start/busy/done handshake to the top level. It sits between the song ROM and the tone generator, inside RR_Module.

Parameters:
ADDR_W, 6, song ROM address width; max 2^ADDR_W entries
PITCH_W, 8, pitch code width passed to the tone generator
DUR_W, 4, note duration field in beats; 0 = end-of-song marker
BEAT_CYCLES, 1000, clock cycles per beat (>=2)
GAP_CYCLES, 8, silence cycles inserted between notes (used only with the optional feature)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin playback from address 0; accepted only in IDLE
stop  in  1  abort playback; return to IDLE on the next edge
loop  in  1  sampled at end-of-song: 1 = restart at address 0
rom_addr  out  ADDR_W  song ROM address
rom_data  in  DUR_W+PITCH_W  entry {dur[DUR_W-1:0], pitch}; valid one cycle after rom_addr is sampled
tone_pitch  out  PITCH_W  pitch code for the tone generator
tone_en  out  1  tone generator enable
note_strobe  out  1  one-cycle pulse on the first cycle of each note
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the song ends without looping

Behaviour:
- Reset (synchronous, active-high): state=IDLE. rom_addr=0, tone_pitch=0, tone_en=0, note_strobe=0, busy=0, done=0. Beat and duration counters cleared.
- States: IDLE, FETCH, WAIT, PLAY, GAP (GAP exists only with the optional feature).
- IDLE: start=1 -> FETCH with rom_addr=0.
- FETCH: the ROM samples rom_addr. Always -> WAIT.
- WAIT: rom_data is valid.
  - dur==0 -> end-of-song.
  - dur!=0 -> latch pitch into tone_pitch and load the duration counter with dur. Set tone_en=1, pulse note_strobe, load beat counter with BEAT_CYCLES-1, go to PLAY.
- Latency: start sampled at edge N -> tone_en=1 and note_strobe=1 from edge N+2.
- PLAY: beat counter decrements every cycle.
  - At 0 it reloads and the duration counter decrements.
  - When the duration counter reaches 0, the note ends: tone_en=0. Without the feature: rom_addr+1 and go to FETCH. With the feature: go to GAP.
  - A note lasts exactly dur*BEAT_CYCLES cycles of tone_en=1.
  - Inter-note silence is 2 cycles (FETCH+WAIT), plus GAP_CYCLES with the feature.
- Address boundary: finishing the note at rom_addr=2^ADDR_W-1 is treated as end-of-song. There is no silent wrap.
- End-of-song (dur==0 or last address): tone_en=0.
  - loop=1 -> rom_addr=0, go to FETCH, no done pulse.
  - loop=0 -> pulse done for one cycle, go to IDLE.
- stop=1 in any non-IDLE state -> IDLE on the next edge: tone_en=0, rom_addr=0, no done pulse. stop has priority over every other transition.
- start while busy is ignored. If start and stop are both 1 in IDLE, stop wins and the block stays in IDLE.
- busy goes high on the edge start is accepted and low on the edge IDLE is re-entered.
- Reset asserted mid-note: all outputs return to reset values on that edge.
- tone_pitch holds the last played value after a note ends; only tone_en gates the sound.

Optional Feature:
- RR_SEQ_GAP_EN defined: the GAP state is compiled in. After each note, tone_en=0 for GAP_CYCLES cycles, then rom_addr+1 and go to FETCH (or end-of-song at the last address). stop aborts GAP as well.
- RR_SEQ_GAP_EN undefined: no GAP state, no gap counter, and GAP_CYCLES is ignored. PLAY goes directly to FETCH.

Decomposition:
- Shared package rr_pkg holds:
  - the state enum typedef (IDLE/FETCH/WAIT/PLAY/GAP)
  - the note-entry struct typedef {dur, pitch}
  - the END_MARKER constant (dur==0)
- One natural sub-module: rr_beat_timer, the BEAT_CYCLES prescaler. It has load/enable inputs and a one-cycle beat_tick output, and is reused by the tempo logic.

Test Plan:
(All scenarios use BEAT_CYCLES=4.)
1. ROM {3,0x21},{2,0x40},{0,x}; start pulse at edge 10.
   - tone_en=1 edges 12-23 (12 cycles), pitch 0x21; then low for 2 cycles.
   - Second note: 8 cycles, pitch 0x40.
   - done pulse once; busy=0 afterwards.
2. Same ROM with loop=1.
   - After entry 2, rom_addr returns to 0 and note 0x21 replays.
   - done never pulses; note_strobe count = 4 after two passes.
3. stop asserted mid-PLAY of the first note.
   - Next edge: tone_en=0, busy=0, rom_addr=0, no done.
   - A subsequent start replays from entry 0.
4. start pulsed during PLAY: ignored, timing unchanged. Reset pulsed mid-note: all outputs equal reset values on that edge.
5. ROM full of nonzero entries (ADDR_W=2, dur=1): exactly 4 notes play, then done with loop=0. Never plays address 0 again.
6. With RR_SEQ_GAP_EN and GAP_CYCLES=3: scenario 1 gives a tone_en low interval of 5 cycles between notes. Without the macro the interval is 2 cycles.
